ni_packetizer: RTL and testbench
================================

// Module: ni_packetizer
// PURPOSE
//  Network-interface TX packetizer on the router's Local input port (L_RX/L_DRTS/L_CTS).
//  Accepts a host command (destination, payload count) and a stream of 28-bit payload words.
//  Emits a header flit followed by body flits; the last flit carries the tail id.
//  Honours the router FIFO's CTS at flit granularity; one flit per cycle maximum.
// PARAMETERS
//  DATA_WIDTH   32    flit width; fixed by the flit format below
//  AXIS         4     router address width (cur_addr, dst)
//  MAX_PAYLOAD  4094  largest legal cmd_len; length field = cmd_len+1 must fit 12 bits
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-low
//  cur_addr   in   4   own router address; goes into the header source field
//  cmd_valid  in   1   packet command offered
//  cmd_ready  out  1   command accepted when cmd_valid & cmd_ready
//  cmd_dst    in   4   destination router address
//  cmd_len    in   12  payload word count N; legal range 1..MAX_PAYLOAD
//  pl_valid   in   1   payload word offered
//  pl_ready   out  1   payload word consumed when pl_valid & pl_ready
//  pl_data    in   28  payload word
//  ni_tx      out  32  flit to router L_RX
//  ni_drts    out  1   flit write strobe to router L_DRTS
//  ni_cts     in   1   router L_CTS; input FIFO can take a flit this cycle
//  busy       out  1   packet in progress (state != IDLE)
//  pkt_done   out  1   1-cycle pulse, registered, after the tail flit is sent
//  err_len    out  1   1-cycle pulse, registered, on a rejected command
// BEHAVIOUR
//  Flit format:
//   [31:29] flit id
//   header: [28:17]=N+1 total flits, [16:13]=dst, [12:9]=cur_addr, [8:1]=seq, [0]=par
//   body/tail: [28:1]=pl_data, [0]=par
//  FSM IDLE -> HDR -> BODY -> IDLE; state, remaining-count, dst and seq are registered.
//  IDLE
//   - cmd_ready=1.
//   - On accept with 1<=cmd_len<=MAX_PAYLOAD: latch dst and len, rem<=cmd_len, go HDR.
//   - On accept with cmd_len=0 or cmd_len>MAX_PAYLOAD: err_len pulses next cycle,
//     no flits are sent, state stays IDLE, seq is unchanged.
//  HDR
//   - ni_drts = ni_cts, comb. Header flit is sent on the first cycle ni_cts=1, then go BODY.
//   - Earliest header is 1 cycle after command accept.
//  BODY
//   - pl_ready = ni_cts, comb. ni_drts = pl_valid & ni_cts.
//   - On each transfer rem decrements. Flit id is TAIL when rem==1, else BODY.
//   - Tail transfer: state goes IDLE, seq increments (8-bit, 255 wraps to 0), pkt_done pulses.
//  Outputs
//   - ni_tx is combinational from the latched fields and pl_data; ni_tx=0 whenever ni_drts=0.
//   - No flit is emitted while ni_cts=0. ni_cts may drop between any two flits;
//     the FSM holds state and rem with no loss or duplication.
//   - Back-to-back: a new command is accepted the cycle after a tail (IDLE again).
//     The next header then comes at minimum one cycle after that.
//  Reset (rst=0, any state, including mid-packet)
//   - State goes IDLE, seq=0, rem=0.
//   - cmd_ready, pl_ready, ni_drts, busy, pkt_done and err_len are all 0 while rst=0.
//   - ni_tx=0 while rst=0.
//   - A partial packet is abandoned; the router side is reset by the same rst.
// CONFIGURATION
//  PARITY_GEN_EN defined: bit[0] of every flit = ^flit[31:1] (even parity over all 32 bits).
//  PARITY_GEN_EN undefined: bit[0] = 0. No other behaviour changes.
// STRUCTURE
//  Package ni_pkg:
//   - FLIT_HDR=3'b001, FLIT_BODY=3'b010, FLIT_TAIL=3'b100
//   - field LSB/width constants
//   - FSM state encoding
//  Single module; no sub-module. Parity is one XOR-reduce under PARITY_GEN_EN.
// TESTING
//  T1: cur_addr=4'h5, cmd dst=4'hA len=3, words 28'h1,2,3, ni_cts=1
//      -> 4 flits on 4 consecutive cycles; header = {001,12'd4,4'hA,4'h5,8'h00,par};
//      ids HDR,BODY,BODY,TAIL; pkt_done pulses once.
//  T2: len=1 -> exactly 2 flits (HDR, TAIL). A second len=1 packet follows
//      -> its header has seq=1.
//  T3: ni_cts toggles 1,0,0,1,0,1 during len=4 -> no ni_drts while cts=0;
//      payload order preserved; exactly 5 flits total.
//  T4: cmd_len=0, then cmd_len=4095 -> err_len pulses twice, no ni_drts, busy stays 0.
//  T5: rst=0 after 2 body flits of a len=5 packet -> all outputs 0;
//      after release cmd_ready=1 and the next header has seq=0.
//  T6: 256 packets of len=1 -> seq field wraps 255->0; with PARITY_GEN_EN
//      every flit XOR-reduces to 0, without it bit[0]=0.

Source files
------------

// File: rtl/ni_pkg.sv
// rtl/ni_pkg.sv - flit ids, flit field positions and FSM encoding for the NI packetizer
package ni_pkg;

    // Flit ids carried in bits [31:29]
    localparam logic [2:0] FLIT_HDR  = 3'b001;
    localparam logic [2:0] FLIT_BODY = 3'b010;
    localparam logic [2:0] FLIT_TAIL = 3'b100;

    // Field positions and widths inside a 32-bit flit
    localparam int ID_LSB  = 29;
    localparam int ID_W    = 3;
    localparam int LEN_LSB = 17;
    localparam int LEN_W   = 12;
    localparam int DST_LSB = 13;
    localparam int SRC_LSB = 9;
    localparam int ADDR_W  = 4;
    localparam int SEQ_LSB = 1;
    localparam int SEQ_W   = 8;
    localparam int PL_LSB  = 1;
    localparam int PL_W    = 28;
    localparam int PAR_BIT = 0;

    // Packetizer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } state_e;

endpackage

// File: rtl/ni_packetizer.sv
// rtl/ni_packetizer.sv - NI TX packetizer (header + body/tail flits), optional PARITY_GEN_EN parity
module ni_packetizer
    import ni_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int AXIS        = 4,
    parameter int MAX_PAYLOAD = 4094
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXIS-1:0]       cur_addr,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [AXIS-1:0]       cmd_dst,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  pl_valid,
    output logic                  pl_ready,
    input  logic [PL_W-1:0]       pl_data,
    output logic [DATA_WIDTH-1:0] ni_tx,
    output logic                  ni_drts,
    input  logic                  ni_cts,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  err_len
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

    state_e               state_q, state_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [AXIS-1:0]      dst_q, dst_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    logic                 pkt_done_q, pkt_done_d;
    logic                 err_len_q, err_len_d;

    logic                 cmd_ready_c;
    logic                 pl_ready_c;
    logic                 drts_c;
    logic                 len_legal;
    logic [DATA_WIDTH-1:0] flit;

    assign len_legal = (cmd_len != '0) && (cmd_len <= MAX_LEN);

    // Next-state logic, handshakes and flit assembly for the current state
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        dst_d       = dst_q;
        seq_d       = seq_q;
        pkt_done_d  = 1'b0;
        err_len_d   = 1'b0;
        cmd_ready_c = 1'b0;
        pl_ready_c  = 1'b0;
        drts_c      = 1'b0;
        flit        = '0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_c = 1'b1;
                if (cmd_valid) begin
                    if (len_legal) begin
                        dst_d   = cmd_dst;
                        rem_d   = cmd_len;
                        state_d = ST_HDR;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                // rem still holds N here, so the length field is rem+1
                drts_c = ni_cts;
                flit   = {FLIT_HDR, rem_q + 12'd1, dst_q, cur_addr, seq_q, 1'b0};
                if (ni_cts) begin
                    state_d = ST_BODY;
                end
            end
            ST_BODY: begin
                pl_ready_c = ni_cts;
                drts_c     = pl_valid & ni_cts;
                flit       = {(rem_q == 12'd1) ? FLIT_TAIL : FLIT_BODY, pl_data, 1'b0};
                if (drts_c) begin
                    rem_d = rem_q - 12'd1;
                    if (rem_q == 12'd1) begin
                        state_d    = ST_IDLE;
                        seq_d      = seq_q + 8'd1;
                        pkt_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef PARITY_GEN_EN
        flit[PAR_BIT] = ^flit[DATA_WIDTH-1:1];
`endif
    end

    // State, counters and latched command fields; pulses are registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            dst_q      <= '0;
            seq_q      <= '0;
            pkt_done_q <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            dst_q      <= dst_d;
            seq_q      <= seq_d;
            pkt_done_q <= pkt_done_d;
            err_len_q  <= err_len_d;
        end
    end

    // Every output is forced low while reset is held, whatever state is left over
    assign cmd_ready = cmd_ready_c & rst;
    assign pl_ready  = pl_ready_c & rst;
    assign ni_drts   = drts_c & rst;
    assign busy      = (state_q != ST_IDLE) & rst;
    assign pkt_done  = pkt_done_q & rst;
    assign err_len   = err_len_q & rst;
    assign ni_tx     = ni_drts ? flit : '0;

endmodule

// File: tb/tb_ni_packetizer.sv
// tb/tb_ni_packetizer.sv - self-checking bench for ni_packetizer (PARITY_GEN_EN aware)
module tb_ni_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cur_addr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_dst;
    logic [11:0] cmd_len;
    logic        pl_valid;
    logic        pl_ready;
    logic [27:0] pl_data;
    logic [31:0] ni_tx;
    logic        ni_drts;
    logic        ni_cts;
    logic        busy;
    logic        pkt_done;
    logic        err_len;

    ni_packetizer dut (
        .clk(clk), .rst(rst), .cur_addr(cur_addr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .ni_tx(ni_tx), .ni_drts(ni_drts), .ni_cts(ni_cts),
        .busy(busy), .pkt_done(pkt_done), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int flit_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit busy_seen = 0;
    bit fire;
    logic [7:0]  model_seq = 8'd0;
    logic [31:0] exp_q[$];
    logic [31:0] log_q[$];
    int          stamp_q[$];
    logic [27:0] pl_q[$];
    logic [27:0] words_q[$];

    function automatic logic [31:0] mk_flit(input logic [2:0] id, input logic [27:0] f);
        logic [31:0] v;
        v = {id, f, 1'b0};
`ifdef PARITY_GEN_EN
        v[0] = ^v[31:1];
`endif
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Packet model: a legal command yields a header then N payload flits, last one TAIL
    task automatic model_accept(input logic [3:0] dst, input logic [11:0] len);
        logic [27:0] w;
        if (len == 12'd0 || len > 12'd4094) return;
        exp_q.push_back(mk_flit(3'b001, {len + 12'd1, dst, cur_addr, model_seq}));
        for (int i = 0; i < int'(len); i++) begin
            w = words_q.pop_front();
            exp_q.push_back(mk_flit((i == int'(len) - 1) ? 3'b100 : 3'b010, w));
        end
        model_seq = model_seq + 8'd1;
    endtask

    task automatic add_word(input logic [27:0] w);
        pl_q.push_back(w);
        words_q.push_back(w);
    endtask

    task automatic send_cmd(input logic [3:0] dst, input logic [11:0] len);
        bit acc = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_dst   = dst;
        cmd_len   = len;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = 1;
                model_accept(dst, len);
            end
        end
        if (!acc) fail_now("cmd_accept");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) ok = 1;
        end
        if (!ok) fail_now("wait_idle");
        repeat (2) @(negedge clk);
    endtask

    // Compare process: every flit against the model, idle bus must be zero
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            check("rst_outs", {26'd0, cmd_ready, pl_ready, ni_drts, busy, pkt_done, err_len}, 32'd0);
            check("rst_tx", ni_tx, 32'd0);
        end else begin
            if (busy) busy_seen = 1;
            if (pkt_done) done_cnt++;
            if (err_len) err_cnt++;
            if (ni_drts) begin
                check("drts_without_cts", {31'd0, ni_cts}, 32'd1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_flit: got %h expected none", ni_tx);
                end else begin
                    check("flit", ni_tx, exp_q.pop_front());
                end
                log_q.push_back(ni_tx);
                stamp_q.push_back(cyc);
                flit_cnt++;
            end else begin
                check("idle_tx", ni_tx, 32'd0);
            end
        end
    end

    // Payload source: presents the head of pl_q, pops it after a handshake
    initial begin
        pl_valid = 1'b0;
        pl_data  = '0;
        forever begin
            @(negedge clk);
            fire = pl_valid && pl_ready;
            @(posedge clk); #2;
            if (fire && pl_q.size() > 0) void'(pl_q.pop_front());
            pl_valid = (pl_q.size() > 0);
            pl_data  = pl_valid ? pl_q[0] : 28'd0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lb, f0, d0, e0, bad;
        logic [27:0] t3w[4];
        t3w[0] = 28'h0000111; t3w[1] = 28'h0000222; t3w[2] = 28'h0000333; t3w[3] = 28'h0000444;
        rst = 1'b0; cur_addr = 4'h5; cmd_valid = 1'b0; cmd_dst = '0; cmd_len = '0; ni_cts = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // T1: len=3 with continuous CTS
        lb = log_q.size(); f0 = flit_cnt; d0 = done_cnt;
        add_word(28'h1); add_word(28'h2); add_word(28'h3);
        send_cmd(4'hA, 12'd3);
        wait_idle();
        check("t1_count", flit_cnt - f0, 4);
        check("t1_hdr", log_q[lb], 32'h20094A00);
        check("t1_body0", log_q[lb+1], 32'h40000002);
        check("t1_body1_id", {29'd0, log_q[lb+2][31:29]}, 32'd2);
`ifdef PARITY_GEN_EN
        check("t1_tail", log_q[lb+3], 32'h80000007);
`else
        check("t1_tail", log_q[lb+3], 32'h80000006);
`endif
        check("t1_consecutive", stamp_q[lb+3] - stamp_q[lb], 3);
        check("t1_pkt_done", done_cnt - d0, 1);

        // T2: two back-to-back len=1 packets
        lb = log_q.size(); f0 = flit_cnt;
        add_word(28'hABCDEF1);
        send_cmd(4'h3, 12'd1);
        add_word(28'h0000123);
        send_cmd(4'h3, 12'd1);
        wait_idle();
        check("t2_count", flit_cnt - f0, 4);
        check("t2_hdr_id", {29'd0, log_q[lb][31:29]}, 32'd1);
        check("t2_tail_id", {29'd0, log_q[lb+1][31:29]}, 32'd4);
        check("t2_seq_a", {24'd0, log_q[lb][8:1]}, 32'd1);
        check("t2_seq_b", {24'd0, log_q[lb+2][8:1]}, 32'd2);
        check("t2_b2b_gap", stamp_q[lb+2] - stamp_q[lb+1], 2);

        // T3: CTS toggling during len=4
        lb = log_q.size(); f0 = flit_cnt;
        for (int i = 0; i < 4; i++) add_word(t3w[i]);
        send_cmd(4'h7, 12'd4);
        foreach (t3w[i]) begin end
        ni_cts = 1'b1; @(posedge clk); #1;
        ni_cts = 1'b0; @(posedge clk); #1;
        ni_cts = 1'b0; @(posedge clk); #1;
        ni_cts = 1'b1; @(posedge clk); #1;
        ni_cts = 1'b0; @(posedge clk); #1;
        ni_cts = 1'b1; @(posedge clk); #1;
        ni_cts = 1'b1;
        wait_idle();
        check("t3_count", flit_cnt - f0, 5);
        for (int i = 0; i < 4; i++) check("t3_order", {4'd0, log_q[lb+1+i][28:1]}, {4'd0, t3w[i]});
        check("t3_span", stamp_q[lb+4] - stamp_q[lb], 7);

        // T4: illegal lengths
        f0 = flit_cnt; e0 = err_cnt; busy_seen = 0;
        send_cmd(4'h2, 12'd0);
        send_cmd(4'h2, 12'd4095);
        repeat (3) @(negedge clk);
        check("t4_err_pulses", err_cnt - e0, 2);
        check("t4_no_flits", flit_cnt - f0, 0);
        check("t4_busy", {31'd0, busy_seen}, 32'd0);

        // T5: reset after two body flits of a len=5 packet
        f0 = flit_cnt;
        for (int i = 0; i < 5; i++) add_word(28'h0000A00 + 28'(i));
        send_cmd(4'h9, 12'd5);
        begin
            bit hit = 0;
            for (int i = 0; i < 50 && !hit; i++) begin
                @(posedge clk);
                if (flit_cnt - f0 >= 3) hit = 1;
            end
            if (!hit) fail_now("t5_partial_wait");
        end
        #1 rst = 1'b0;
        exp_q.delete(); pl_q.delete(); words_q.delete(); model_seq = 8'd0;
        @(negedge clk);
        check("t5_in_reset", {26'd0, cmd_ready, pl_ready, ni_drts, busy, pkt_done, err_len}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t5_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("t5_partial", flit_cnt - f0, 3);
        lb = log_q.size();
        add_word(28'h5555555);
        send_cmd(4'h1, 12'd1);
        wait_idle();
        check("t5_seq", {24'd0, log_q[lb][8:1]}, 32'd0);

        // T6: 256 single-word packets, seq wraps
        lb = log_q.size(); f0 = flit_cnt; d0 = done_cnt;
        for (int i = 0; i < 256; i++) begin
            add_word(28'(i * 7 + 1));
            send_cmd(4'h4, 12'd1);
        end
        wait_idle();
        check("t6_count", flit_cnt - f0, 512);
        check("t6_done", done_cnt - d0, 256);
        check("t6_seq_255", {24'd0, log_q[lb+508][8:1]}, 32'd255);
        check("t6_seq_wrap", {24'd0, log_q[lb+510][8:1]}, 32'd0);
        bad = 0;
        foreach (log_q[i]) begin
`ifdef PARITY_GEN_EN
            if (^log_q[i] !== 1'b0) bad++;
`else
            if (log_q[i][0] !== 1'b0) bad++;
`endif
        end
        check("parity_all", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
